// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module   : mem_access_pkg
// Brief    : funct3 codes, FSM encoding, error causes and access-size helpers
//            shared by the memory access unit and its load aligner.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;
  localparam logic [2:0] c_F3_SB  = 3'b000;
  localparam logic [2:0] c_F3_SH  = 3'b001;
  localparam logic [2:0] c_F3_SW  = 3'b010;

  localparam logic [1:0] c_ERR_NONE     = 2'b00;
  localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] c_ERR_RANGE    = 2'b10;
  localparam logic [1:0] c_ERR_RDWR     = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  // Unlisted funct3 codes fall back to a full-word access.
  function automatic size_t load_size(input logic [2:0] f3);
    case (f3)
      c_F3_LB, c_F3_LBU: load_size = SZ_BYTE;
      c_F3_LH, c_F3_LHU: load_size = SZ_HALF;
      default:           load_size = SZ_WORD;
    endcase
  endfunction

  function automatic size_t store_size(input logic [2:0] f3);
    case (f3)
      c_F3_SB: store_size = SZ_BYTE;
      c_F3_SH: store_size = SZ_HALF;
      default: store_size = SZ_WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module   : load_align
// Brief    : Selects the addressed byte/half/word lane of a memory word and
//            sign- or zero-extends it to 32 bits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] dm_rd,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  always_comb begin
    case (addr_lo)
      2'b00:   w_byte = dm_rd[7:0];
      2'b01:   w_byte = dm_rd[15:8];
      2'b10:   w_byte = dm_rd[23:16];
      default: w_byte = dm_rd[31:24];
    endcase
  end

  assign w_half   = addr_lo[1] ? dm_rd[31:16] : dm_rd[15:0];
  assign w_signed = ~funct3[2];

  always_comb begin
    case (load_size(funct3))
      SZ_BYTE: rdata = {{24{w_signed & w_byte[7]}}, w_byte};
      SZ_HALF: rdata = {{16{w_signed & w_half[15]}}, w_half};
      default: rdata = dm_rd;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store initiator for a word-only data memory, with
//            read-modify-write sub-word stores and request error checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic              dm_re,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wd,
  input  logic [31:0]       dm_rd
);

  // One extra bit so MEM_WORDS*4 == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] c_LIMIT = (ADDR_W+1)'(64'(MEM_WORDS) * 64'd4);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_merged;

  logic                w_active;
  logic                w_store;
  size_t               w_size;
  logic                w_misaligned;
  logic                w_oor;
  logic [1:0]          w_cause;
  logic                w_err;
  logic                w_start_rmw;
  logic [ADDR_W-1:0]   w_word_addr;
  logic [31:0]         w_merged;
  logic [31:0]         w_load;

  assign w_active     = req_valid & (mem_read | mem_write);
  assign w_store      = mem_write & ~mem_read;
  assign w_size       = w_store ? store_size(funct3) : load_size(funct3);
  assign w_misaligned = ((w_size == SZ_HALF) & addr[0]) |
                        ((w_size == SZ_WORD) & (|addr[1:0]));
  assign w_oor        = {1'b0, addr} >= c_LIMIT;
  assign w_word_addr  = {addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    if (mem_read & mem_write) w_cause = c_ERR_RDWR;
    else if (w_misaligned)    w_cause = c_ERR_MISALIGN;
    else if (w_oor)           w_cause = c_ERR_RANGE;
    else                      w_cause = c_ERR_NONE;
  end

  assign w_err       = (r_state == ST_IDLE) & w_active & (w_cause != c_ERR_NONE);
  assign w_start_rmw = (r_state == ST_IDLE) & w_active & ~w_err & w_store &
                       (w_size != SZ_WORD);

  // Current memory word with the addressed lane overwritten by store data.
  always_comb begin
    w_merged = dm_rd;
    if (w_size == SZ_BYTE) begin
      case (addr[1:0])
        2'b00:   w_merged[7:0]   = wdata[7:0];
        2'b01:   w_merged[15:8]  = wdata[7:0];
        2'b10:   w_merged[23:16] = wdata[7:0];
        default: w_merged[31:24] = wdata[7:0];
      endcase
    end else if (addr[1]) begin
      w_merged[31:16] = wdata[15:0];
    end else begin
      w_merged[15:0]  = wdata[15:0];
    end
  end

  load_align u_load_align (
    .dm_rd   (dm_rd),
    .addr_lo (addr[1:0]),
    .funct3  (funct3),
    .rdata   (w_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_merged <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_rmw) begin
            r_state  <= ST_RMW_WR;
            r_addr   <= w_word_addr;
            r_merged <= w_merged;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready   = 1'b1;
    rdata       = '0;
    rdata_valid = 1'b0;
    err         = 1'b0;
    err_cause   = c_ERR_NONE;
    dm_re       = 1'b0;
    dm_we       = 1'b0;
    dm_addr     = '0;
    dm_wd       = '0;
    if (!rst) begin
      // Reset forces everything idle, abandoning any in-flight write.
    end else if (r_state == ST_RMW_WR) begin
      if (!flush) begin
        dm_we   = 1'b1;
        dm_addr = r_addr;
        dm_wd   = r_merged;
      end
    end else if (w_active) begin
      if (w_err) begin
        err       = 1'b1;
        err_cause = w_cause;
      end else if (mem_read) begin
        dm_re       = 1'b1;
        dm_addr     = w_word_addr;
        rdata       = w_load;
        rdata_valid = 1'b1;
      end else if (w_size == SZ_WORD) begin
        dm_we   = 1'b1;
        dm_addr = w_word_addr;
        dm_wd   = wdata;
      end else begin
        dm_re     = 1'b1;
        dm_addr   = w_word_addr;
        req_ready = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit with a
//            word-addressed memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic [1:0]  err_cause;
  logic        dm_re;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  logic [31:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  mem_access_unit #(
    .ADDR_W    (32),
    .MEM_WORDS (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .flush       (flush),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .err_cause   (err_cause),
    .dm_re       (dm_re),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wd       (dm_wd),
    .dm_rd       (dm_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rd = mem[dm_addr[11:2]];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[11:2]] <= dm_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic fl);
    req_valid = v;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    flush     = fl;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                      input string tag);
    drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0, 1'b0);
    @(negedge clk);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_valid"}, {31'b0, rdata_valid}, 32'd1);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    next_cycle();
  endtask

  task automatic expect_err(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [1:0] cause, input string tag);
    drive(1'b1, rd, wr, f3, a, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check({tag, "_err"}, {31'b0, err}, 32'd1);
    check({tag, "_cause"}, {30'b0, err_cause}, {30'b0, cause});
    check({tag, "_we_re"}, {30'b0, dm_we, dm_re}, 32'd0);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_rvalid"}, {31'b0, rdata_valid}, 32'd0);
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[16] = 32'h8899AABB;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h12345678, 1'b0);

    // Reset holds all enables low even with a valid store presented.
    @(negedge clk);
    check("rst_we_re", {30'b0, dm_we, dm_re}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_err_rv", {30'b0, err, rdata_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    next_cycle();

    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h40, 32'h0, 1'b0);
    @(negedge clk);
    check("idle_out", {28'b0, dm_we, dm_re, err, rdata_valid}, 32'd0);
    check("idle_ready", {31'b0, req_ready}, 32'd1);
    next_cycle();

    // Loads from 0x8899AABB.
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h41, 32'h0, 1'b0);
    @(negedge clk);
    check("lb41_re", {31'b0, dm_re}, 32'd1);
    check("lb41_addr", dm_addr, 32'h40);
    next_cycle();
    load(3'b000, 32'h41, 32'hFFFFFFAA, "lb41");
    load(3'b100, 32'h41, 32'h000000AA, "lbu41");
    load(3'b001, 32'h42, 32'hFFFF8899, "lh42");
    load(3'b101, 32'h40, 32'h0000AABB, "lhu40");
    load(3'b000, 32'h43, 32'hFFFFFF88, "lb43");
    load(3'b000, 32'h40, 32'hFFFFFFBB, "lb40");
    load(3'b111, 32'h40, 32'h8899AABB, "lw_illegal");

    // SH 0x1234 at 0x42; cycle-1 inputs change but must be ignored.
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h42, 32'h00001234, 1'b0);
    @(negedge clk);
    check("sh_c0_ready", {31'b0, req_ready}, 32'd0);
    check("sh_c0_re_we", {30'b0, dm_re, dm_we}, 32'd2);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h42, 32'h0000FFFF, 1'b0);
    @(negedge clk);
    check("sh_c1_we", {31'b0, dm_we}, 32'd1);
    check("sh_c1_wd", dm_wd, 32'h1234AABB);
    check("sh_c1_addr", dm_addr, 32'h40);
    check("sh_c1_ready", {31'b0, req_ready}, 32'd1);
    next_cycle();
    load(3'b010, 32'h40, 32'h1234AABB, "lw_after_sh");

    // Error checks and priority.
    expect_err(1'b1, 1'b0, 3'b010, 32'h46, 2'b01, "lw46");
    expect_err(1'b0, 1'b1, 3'b010, 32'h46, 2'b01, "sw46");
    load(3'b010, 32'h44, 32'h00000000, "lw44_unchanged");
    expect_err(1'b0, 1'b1, 3'b010, 32'h1000, 2'b10, "sw1000");
    expect_err(1'b1, 1'b0, 3'b001, 32'h41, 2'b01, "lh41");
    expect_err(1'b1, 1'b1, 3'b001, 32'h41, 2'b11, "rdwr");
    expect_err(1'b1, 1'b0, 3'b010, 32'h1002, 2'b01, "mis_oor");

    // Last in-range word; flush in IDLE is ignored.
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'hFFC, 32'hA5A5A5A5, 1'b1);
    @(negedge clk);
    check("swffc_we", {31'b0, dm_we}, 32'd1);
    check("swffc_wd", dm_wd, 32'hA5A5A5A5);
    check("swffc_ready", {31'b0, req_ready}, 32'd1);
    next_cycle();
    load(3'b010, 32'hFFC, 32'hA5A5A5A5, "lwffc");

    // Illegal store funct3 behaves as SW.
    drive(1'b1, 1'b0, 1'b1, 3'b101, 32'h84, 32'h01020304, 1'b0);
    @(negedge clk);
    check("sw_illegal_we", {31'b0, dm_we}, 32'd1);
    check("sw_illegal_ready", {31'b0, req_ready}, 32'd1);
    next_cycle();
    load(3'b010, 32'h84, 32'h01020304, "lw84");

    // SB with flush in cycle 1 is abandoned.
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h40, 32'h00000077, 1'b0);
    @(negedge clk);
    check("sbfl_c0_ready", {31'b0, req_ready}, 32'd0);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("sbfl_c1_we", {31'b0, dm_we}, 32'd0);
    check("sbfl_c1_ready", {31'b0, req_ready}, 32'd1);
    next_cycle();
    load(3'b010, 32'h40, 32'h1234AABB, "lw_after_flush");

    // Reset during cycle 1 of an SB drops the write at once.
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h40, 32'h00000055, 1'b0);
    @(negedge clk);
    check("sbrst_c0_ready", {31'b0, req_ready}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("sbrst_we", {31'b0, dm_we}, 32'd0);
    check("sbrst_ready", {31'b0, req_ready}, 32'd1);
    next_cycle();
    rst = 1'b1;
    load(3'b010, 32'h40, 32'h1234AABB, "lw_after_rst");
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    check("sw_post_rst_we", {31'b0, dm_we}, 32'd1);
    next_cycle();
    load(3'b010, 32'h40, 32'hCAFEF00D, "lw_post_rst");

    // Back-to-back SBs on a zero word: ready goes 0,1,0,1.
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h80, 32'h00000011, 1'b0);
    @(negedge clk);
    check("b2b_c0_ready", {31'b0, req_ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("b2b_c1_ready", {31'b0, req_ready}, 32'd1);
    check("b2b_c1_wd", dm_wd, 32'h00000011);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h81, 32'h00000022, 1'b0);
    @(negedge clk);
    check("b2b_c2_ready", {31'b0, req_ready}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("b2b_c3_ready", {31'b0, req_ready}, 32'd1);
    check("b2b_c3_wd", dm_wd, 32'h00002211);
    next_cycle();
    load(3'b010, 32'h80, 32'h00002211, "lw_b2b");

    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator sitting in the MEM stage between the pipeline and the word-addressed data memory. Translates RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-wide memory transactions. Performs read-modify-write for sub-word stores, since the memory only writes whole words. Also performs sign or zero extension of load data and flags misaligned, out-of-range and illegal requests. Stalls the pipeline through a ready handshake while a read-modify-write is in flight.

## Interface
- ADDR_W, 32, byte-address width
- MEM_WORDS, 1024, number of 32-bit words in the data memory; addresses at or beyond MEM_WORDS*4 are out of range
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-low
- req_valid  in  1  MEM stage presents a memory operation
- req_ready  out  1  operation completes this cycle; low means stall the pipeline
- mem_read  in  1  load request
- mem_write  in  1  store request
- funct3  in  3  RISC-V width/sign code
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-aligned
- flush  in  1  cancel any pending sub-word store
- rdata  out  32  extended load result
- rdata_valid  out  1  rdata is meaningful this cycle
- err  out  1  request rejected this cycle
- err_cause  out  2  01 misaligned, 10 out of range, 11 read and write both set
- dm_re  out  1  memory read enable
- dm_we  out  1  memory write enable
- dm_addr  out  ADDR_W  memory address; bits [1:0] are always 0
- dm_wd  out  32  memory write data
- dm_rd  in  32  memory read data, combinational from dm_addr

## Operation
- FSM states: IDLE and RMW_WR.
- Error checks are evaluated in IDLE when req_valid is high, in this priority order:
  - read and write both set: cause 11.
  - misaligned: cause 01. Halfword needs addr[0]=0; word needs addr[1:0]=0.
  - out of range: cause 10.
- On any error:
  - err=1 and req_ready=1.
  - dm_we=0 and dm_re=0.
  - rdata_valid=0 and rdata=0.
  - The operation is consumed; trap handling is outside this block.
- Load in IDLE:
  - dm_re=1 and dm_addr={addr[ADDR_W-1:2],2'b00}.
  - rdata is the byte or half selected from dm_rd.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - Byte lane is addr[1:0]; half lane is addr[1].
  - rdata_valid=1 and req_ready=1.
- SW in IDLE: dm_we=1, dm_wd=wdata, req_ready=1.
- SB or SH in IDLE:
  - dm_re=1 and req_ready=0.
  - On the clock edge, latch the word address and the merged word, then go to RMW_WR.
  - The merged word is dm_rd with the selected lane replaced by wdata[7:0] or wdata[15:0].
- RMW_WR:
  - dm_we=1, dm_wd=merged register, dm_addr=latched address, req_ready=1.
  - Return to IDLE.
  - Inputs are ignored in this state; the latched copies are used.
- flush high in RMW_WR: dm_we=0, req_ready=1, return to IDLE. The store is abandoned.
- flush has no effect in IDLE.
- funct3 values outside the eight legal codes are treated as LW or SW.
- req_valid low in IDLE: all enables 0, req_ready=1, outputs 0.

## Timing
- While rst is low:
  - State is IDLE and the latch registers are 0.
  - dm_we and dm_re are forced to 0 combinationally.
  - req_ready=1, and rdata, rdata_valid and err are 0.
- Reset asserted mid-RMW: the write is abandoned immediately; no partial write occurs.
- Latency:
  - Loads, SW and errors complete in the same cycle: req_ready is high in the accept cycle.
  - SB and SH take 2 cycles: req_ready is low in cycle 0 and high in cycle 1.
  - The memory is written at the end of cycle 1.
- Handshake: the pipeline holds every request input stable while req_ready=0.
- Back-to-back: a new request may be presented in the cycle after RMW_WR. No bubble is inserted.
- Store followed by a load to the same word: the load in the next cycle sees the new data, because the memory writes on the edge.

## Structure
- Package mem_access_pkg holds:
  - funct3 constants for LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encoding.
  - err_cause codes.
- Sub-module load_align, purely combinational: takes dm_rd, addr[1:0] and funct3 and produces the extended rdata.
- FSM, merge logic and error checks stay in mem_access_unit.

## Test plan
- Memory word 0x40 = 0x8899AABB, LB at 0x41 -> rdata=0xFFFFFFAA, rdata_valid=1, req_ready=1 in the same cycle. LBU at 0x41 -> 0x000000AA.
- Memory word 0x40 = 0x8899AABB, SH wdata=0x1234 at 0x42:
  - cycle 0: req_ready=0, dm_re=1.
  - cycle 1: dm_we=1, dm_wd=0x1234AABB, req_ready=1.
  - A following LW at 0x40 returns 0x1234AABB.
- LW at 0x46 -> err=1, err_cause=01, dm_we=0, memory unchanged. SW at 0x1000 with MEM_WORDS=1024 -> err_cause=10.
- SB at 0x40 with flush asserted in cycle 1 -> dm_we=0, memory word unchanged, req_ready=1, state IDLE.
- rst pulled low during cycle 1 of an SB -> dm_we drops immediately, memory unchanged. After release, an SW completes normally.
- Back-to-back SB at 0x40 (0x11) then SB at 0x41 (0x22) on a word of 0 -> final word 0x00002211, 4 cycles total.
